// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder
//  Description : Memory-side responder for the MOV/R_W/DT/MOC four-phase
//                handshake. Owns a 2**ADDR_W byte, big-endian array and
//                serves byte, halfword, word and doubleword (two word beats)
//                transfers after WAIT_CYCLES programmable wait states.
//                Optional macro MISALIGN_TRAP_EN: misaligned requests are
//                answered immediately with err=1 instead of being masked.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              MOV,
  input  logic              R_W,
  input  logic [1:0]        DT,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              MOC,
  output logic              err
);

  localparam int         C_DEPTH     = 1 << ADDR_W;
  localparam logic [3:0] C_WAIT_LAST = 4'(WAIT_CYCLES - 1);
  localparam logic [1:0] C_DT_HALF   = 2'b01;
  localparam logic [1:0] C_DT_DWORD  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_ACCESS = 3'd2,
    S_HOLD   = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_beat;
  logic              r_rw;
  logic [1:0]        r_dt;
  logic [ADDR_W-1:0] r_addr;     // aligned base of the current beat
  logic [31:0]       r_wdata;
  logic              r_trap;     // current request is answered with err
  logic [31:0]       r_data_out;
  logic              r_moc;
  logic              r_err;
  logic [7:0]        r_mem [C_DEPTH];

  logic [ADDR_W-1:0] w_base;
  logic              w_misalign;
  logic [ADDR_W-1:0] w_lane_addr  [4];
  logic [7:0]        w_lane_wdata [4];
  logic [3:0]        w_lane_en;
  logic [31:0]       w_rdata;
  logic              w_do_write;

  assign data_out = r_data_out;
  assign MOC      = r_moc;
  assign err      = r_err;

  // Incoming address with the low bits ignored according to transfer size
  always_comb begin
    w_base = address;
    if (DT == C_DT_HALF) begin
      w_base[0] = 1'b0;
    end else if (DT[1]) begin
      w_base[1:0] = 2'b00;
    end
  end

`ifdef MISALIGN_TRAP_EN
  // Misalignment detection on the incoming request
  always_comb begin
    w_misalign = 1'b0;
    if (DT == C_DT_HALF) begin
      w_misalign = address[0];
    end else if (DT[1]) begin
      w_misalign = |address[1:0];
    end
  end
`else
  assign w_misalign = 1'b0;
`endif

  // Big-endian lane mapping: lane k is byte address base+k (wrapping)
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_lane_addr[k]  = r_addr + ADDR_W'(k);
      w_lane_wdata[k] = r_wdata[8*(3-k) +: 8];
    end
    case (r_dt)
      2'b00: begin
        w_lane_en       = 4'b0001;
        w_lane_wdata[0] = r_wdata[7:0];
        w_rdata         = {24'b0, r_mem[w_lane_addr[0]]};
      end
      2'b01: begin
        w_lane_en       = 4'b0011;
        w_lane_wdata[0] = r_wdata[15:8];
        w_lane_wdata[1] = r_wdata[7:0];
        w_rdata         = {16'b0, r_mem[w_lane_addr[0]], r_mem[w_lane_addr[1]]};
      end
      default: begin
        w_lane_en = 4'b1111;
        w_rdata   = {r_mem[w_lane_addr[0]], r_mem[w_lane_addr[1]],
                     r_mem[w_lane_addr[2]], r_mem[w_lane_addr[3]]};
      end
    endcase
  end

  assign w_do_write = (r_state == S_ACCESS) && !r_trap && !r_rw;

  // Array write, committed only on the ACCESS edge of a write beat
  always_ff @(posedge clk) begin
    if (w_do_write) begin
      for (int k = 0; k < 4; k++) begin
        if (w_lane_en[k]) begin
          r_mem[w_lane_addr[k]] <= w_lane_wdata[k];
        end
      end
    end
  end

  // Handshake sequencer with registered MOC / err / data_out
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_beat     <= 1'b0;
      r_rw       <= 1'b0;
      r_dt       <= 2'b00;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
      r_trap     <= 1'b0;
      r_data_out <= 32'd0;
      r_moc      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (MOV) begin
            r_rw    <= R_W;
            r_dt    <= DT;
            r_addr  <= w_base;
            r_wdata <= data_in;
            r_beat  <= 1'b0;
            r_cnt   <= 4'd0;
            r_trap  <= w_misalign;
            // An error response skips the wait states entirely
            if (w_misalign || WAIT_CYCLES == 0) begin
              r_state <= S_ACCESS;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!MOV) begin
            r_state <= S_IDLE;
          end else if (r_cnt == C_WAIT_LAST) begin
            r_cnt   <= 4'd0;
            r_state <= S_ACCESS;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_ACCESS: begin
          r_moc <= 1'b1;
          if (r_trap) begin
            r_err      <= 1'b1;
            r_data_out <= 32'd0;
            r_state    <= S_HOLD;
          end else begin
            if (r_rw) begin
              r_data_out <= w_rdata;
            end
            // First beat of a doubleword only pulses MOC for one cycle
            if (r_dt == C_DT_DWORD && !r_beat) begin
              r_state <= S_GAP;
            end else begin
              r_state <= S_HOLD;
            end
          end
        end
        S_GAP: begin
          r_moc <= 1'b0;
          if (!MOV) begin
            r_state <= S_IDLE;
          end else begin
            r_beat  <= 1'b1;
            r_addr  <= r_addr + ADDR_W'(4);
            r_wdata <= data_in;
            r_cnt   <= 4'd0;
            r_state <= (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
          end
        end
        S_HOLD: begin
          if (!MOV) begin
            r_moc   <= 1'b0;
            r_err   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_responder
//  Description : Self-checking bench for mem_responder. A byte-array model
//                and a transaction-level timeline give the expected MOC,
//                err and data_out for every cycle; a single compare process
//                checks them on each falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  localparam int W = 2;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr;
  logic        MOV;
  logic        R_W;
  logic [1:0]  DT;
  logic [7:0]  address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        MOC;
  logic        err;

  mem_responder #(.WAIT_CYCLES(W), .ADDR_W(8)) dut (
    .clk      (clk),
    .clr      (clr),
    .MOV      (MOV),
    .R_W      (R_W),
    .DT       (DT),
    .address  (address),
    .data_in  (data_in),
    .data_out (data_out),
    .MOC      (MOC),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  bit [7:0]  mm [256];
  bit        exp_moc   = 1'b0;
  bit        exp_err   = 1'b0;
  bit [31:0] exp_dout  = 32'd0;
  bit        chk_dout  = 1'b0;
  bit        chk_on    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [7:0] amask(input bit [7:0] a, input bit [1:0] dt);
    if (dt == 2'b01) return {a[7:1], 1'b0};
    if (dt[1])       return {a[7:2], 2'b00};
    return a;
  endfunction

  function automatic bit misal(input bit [7:0] a, input bit [1:0] dt);
    return (dt == 2'b01 && a[0]) || (dt[1] && a[1:0] != 2'b00);
  endfunction

  function automatic bit [31:0] mread(input bit [7:0] b, input bit [1:0] sz);
    if (sz == 2'b00) return {24'd0, mm[b]};
    if (sz == 2'b01) return {16'd0, mm[b], mm[b + 8'd1]};
    return {mm[b], mm[b + 8'd1], mm[b + 8'd2], mm[b + 8'd3]};
  endfunction

  function automatic void mwrite(input bit [7:0] b, input bit [1:0] sz, input bit [31:0] d);
    if (sz == 2'b00) begin
      mm[b] = d[7:0];
    end else if (sz == 2'b01) begin
      mm[b] = d[15:8]; mm[b + 8'd1] = d[7:0];
    end else begin
      mm[b] = d[31:24]; mm[b + 8'd1] = d[23:16];
      mm[b + 8'd2] = d[15:8]; mm[b + 8'd3] = d[7:0];
    end
  endfunction

  // Per-cycle comparison of DUT outputs against the expected timeline
  always @(negedge clk) begin
    if (chk_on && !clr) begin
      chk("moc", MOC, exp_moc);
      chk("err", err, exp_err);
      if (exp_moc && chk_dout) chk("data_out", data_out, exp_dout);
    end
  end

  // One transaction; called just after a rising edge. drop_in<0 means normal
  // completion with `hold` extra MOC cycles, otherwise MOV falls right after
  // edge t+drop_in (t = request sample edge).
  task automatic txn(input bit rw, input bit [1:0] dt, input bit [7:0] a,
                     input bit [31:0] d0, input bit [31:0] d1,
                     input int drop_in, input int hold, output bit [31:0] rd);
    int drop, acc0, gp, acc1, last, n;
    bit mis, dw, live, mov;
    bit [7:0] b;
    bit [1:0] sz;
    rd   = 32'd0;
    b    = amask(a, dt);
    mis  = TRAP && misal(a, dt);
    dw   = (dt == 2'b11) && !mis;
    sz   = (dt == 2'b11) ? 2'b10 : dt;
    acc0 = mis ? 1 : W + 1;
    gp   = acc0 + 1;
    acc1 = gp + W + 1;
    last = dw ? acc1 : acc0;
    drop = (drop_in < 0) ? last + hold : drop_in;
    MOV = 1'b1; R_W = rw; DT = dt; address = a; data_in = d0;
    @(posedge clk); #1;
    if (drop == 0) MOV = 1'b0;
    live = 1'b1;
    n = 0;
    while (live) begin
      @(posedge clk); #1;
      n++;
      mov = (n <= drop);
      if (n == acc0) begin
        exp_moc  = 1'b1;
        exp_err  = mis;
        chk_dout = rw || mis;
        if (mis)     exp_dout = 32'd0;
        else if (rw) exp_dout = mread(b, sz);
        else         mwrite(b, sz, d0);
        if (n == last) rd = data_out;
        if (dw) data_in = d1;
      end else if (dw && n == gp) begin
        exp_moc = 1'b0;
        if (!mov) live = 1'b0;
      end else if (dw && n == acc1) begin
        exp_moc = 1'b1;
        if (rw) exp_dout = mread(b + 8'd4, 2'b10);
        else    mwrite(b + 8'd4, 2'b10, d1);
        rd = data_out;
      end else if (n < last) begin
        if (!mov) live = 1'b0;
      end else begin
        if (!mov) begin
          exp_moc = 1'b0;
          exp_err = 1'b0;
          live    = 1'b0;
        end
      end
      if (n == drop) MOV = 1'b0;
    end
  endtask

  initial begin
    bit [31:0] rd, prev;
    clr = 1'b1; MOV = 1'b0; R_W = 1'b0; DT = 2'b00; address = 8'd0; data_in = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_moc", MOC, 32'd0);
    chk("reset_err", err, 32'd0);
    chk("reset_dout", data_out, 32'd0);
    clr = 1'b0;
    chk_on = 1'b1;
    @(posedge clk); #1;

    // Fill the whole array with known random words
    for (int i = 0; i < 64; i++) txn(1'b0, 2'b10, 8'(i * 4), $urandom, 32'd0, -1, 0, rd);

    // Word write then big-endian byte reads
    txn(1'b0, 2'b10, 8'h10, 32'hDEADBEEF, 32'd0, -1, 1, rd);
    txn(1'b1, 2'b00, 8'h10, 32'd0, 32'd0, -1, 0, rd);
    chk("byte_rd_10", rd, 32'h000000DE);
    txn(1'b1, 2'b00, 8'h13, 32'd0, 32'd0, -1, 2, rd);
    chk("byte_rd_13", rd, 32'h000000EF);

    // Halfword write / reads
    txn(1'b0, 2'b01, 8'h20, 32'h00001234, 32'd0, -1, 0, rd);
    txn(1'b1, 2'b01, 8'h20, 32'd0, 32'd0, -1, 0, rd);
    chk("half_rd_20", rd, 32'h00001234);
    txn(1'b1, 2'b00, 8'h20, 32'd0, 32'd0, -1, 0, rd);
    chk("byte_rd_20", rd, 32'h00000012);
    txn(1'b1, 2'b00, 8'h21, 32'd0, 32'd0, -1, 0, rd);
    chk("byte_rd_21", rd, 32'h00000034);

    // Doubleword write wrapping past the top of the array
    txn(1'b0, 2'b11, 8'hFC, 32'h11111111, 32'h22222222, -1, 1, rd);
    txn(1'b1, 2'b10, 8'hFC, 32'd0, 32'd0, -1, 0, rd);
    chk("word_rd_fc", rd, 32'h11111111);
    txn(1'b1, 2'b10, 8'h00, 32'd0, 32'd0, -1, 0, rd);
    chk("word_rd_00", rd, 32'h22222222);
    txn(1'b1, 2'b11, 8'hFC, 32'd0, 32'd0, -1, 0, rd);
    chk("dword_rd_beat1", rd, 32'h22222222);

    // Abort after one wait cycle leaves memory untouched
    prev = mread(8'h40, 2'b10);
    txn(1'b0, 2'b10, 8'h40, 32'hFFFF0000, 32'd0, 1, 0, rd);
    txn(1'b1, 2'b10, 8'h40, 32'd0, 32'd0, -1, 0, rd);
    chk("abort_rd_40", rd, prev);

    // Doubleword write aborted during the beat-0 pulse: only beat 0 lands
    prev = mread(8'h84, 2'b10);
    txn(1'b0, 2'b11, 8'h80, 32'hA1A2A3A4, 32'hB1B2B3B4, W + 1, 0, rd);
    txn(1'b1, 2'b10, 8'h80, 32'd0, 32'd0, -1, 0, rd);
    chk("dw_abort_beat0", rd, 32'hA1A2A3A4);
    txn(1'b1, 2'b10, 8'h84, 32'd0, 32'd0, -1, 0, rd);
    chk("dw_abort_beat1", rd, prev);

    // Asynchronous reset during the wait of a write
    txn(1'b1, 2'b10, 8'h10, 32'd0, 32'd0, -1, 0, rd);
    prev = mread(8'h50, 2'b10);
    MOV = 1'b1; R_W = 1'b0; DT = 2'b10; address = 8'h50; data_in = 32'hA5A5A5A5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_clr_dout", data_out, 32'hDEADBEEF);
    chk_on = 1'b0;
    clr = 1'b1;
    #1;
    chk("clr_moc", MOC, 32'd0);
    chk("clr_dout", data_out, 32'd0);
    chk("clr_err", err, 32'd0);
    MOV = 1'b0;
    @(posedge clk); #1;
    clr = 1'b0;
    exp_moc = 1'b0; exp_err = 1'b0;
    chk_on = 1'b1;
    @(posedge clk); #1;
    txn(1'b1, 2'b10, 8'h50, 32'd0, 32'd0, -1, 0, rd);
    chk("clr_no_write_50", rd, prev);

    // Misaligned word read
    txn(1'b0, 2'b10, 8'h30, 32'hCAFEF00D, 32'd0, -1, 0, rd);
    txn(1'b1, 2'b10, 8'h31, 32'd0, 32'd0, -1, 1, rd);
    chk("misalign_rd_31", rd, TRAP ? 32'd0 : 32'hCAFEF00D);

    // Randomized traffic with occasional aborts
    for (int i = 0; i < 200; i++) begin
      bit        rw;
      bit [1:0]  dt;
      bit [7:0]  a;
      int        drop;
      rw = 1'($urandom_range(0, 1));
      dt = 2'($urandom_range(0, 3));
      a  = 8'($urandom);
      drop = -1;
      if (!(TRAP && misal(a, dt)) && $urandom_range(0, 4) == 0) begin
        if (dt == 2'b11 && $urandom_range(0, 1) == 1)
          drop = ($urandom_range(0, 1) == 1) ? W + 1 : W + 2 + int'($urandom_range(0, W - 1));
        else
          drop = int'($urandom_range(0, W - 1));
      end
      txn(rw, dt, a, $urandom, $urandom, drop, int'($urandom_range(0, 3)), rd);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
